// File: rtl/tdm_transmit.sv
// TDM serial audio transmitter: double-buffered parallel frames out as sck/ws/sd.
// Latency: a frame accepted before a load point is sent in the frame that load starts.
// Backpressure: audio_ready_out is low while the holding buffer is full; the stream never stalls.
// Optional build macro: TDM_TX_UNDERRUN_REPEAT_EN repeats the last loaded frame on underrun.
`timescale 1ns/1ps
module tdm_transmit #(
  parameter int BIT_WIDTH   = 24,
  parameter int SLOTS       = 4,
  parameter int SLOT_CYCLES = 32,
  parameter int CLK_DIV     = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in_n,
  input  logic [SLOTS*BIT_WIDTH-1:0]   audio_in,
  input  logic                         audio_valid_in,
  output logic                         audio_ready_out,
  output logic                         sck_out,
  output logic                         ws_out,
  output logic                         sd_out,
  output logic                         frame_start_out,
  output logic                         underrun_out
);

  localparam int FW   = SLOTS * BIT_WIDTH;
  localparam int PMAX = SLOTS * SLOT_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = $clog2(SLOT_CYCLES + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);

  localparam logic [PW-1:0] P_LAST = PW'(PMAX);
  localparam logic [BW-1:0] B_LAST = BW'(SLOT_CYCLES - 1);
  localparam logic [BW-1:0] B_DATA = BW'(BIT_WIDTH);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          sck_q;
  logic          started;
  logic [PW-1:0] p_cnt;
  logic [BW-1:0] b_cnt;
  logic [FW-1:0] ser;
  logic [FW-1:0] hold_dat;
  logic          hold_full;
  logic [FW-1:0] hold_ser;
  logic [FW-1:0] under_ser;
  logic          ws_q;
  logic          sd_q;
  logic          fs_q;
  logic          ur_q;
  logic          div_wrap;
  logic          period_start;
  logic          load;
  logic          accept;

  assign div_wrap     = (div_cnt == D_LAST);
  // A period begins on the sck falling edge, or on the very first clock after reset.
  assign period_start = !started || (div_wrap && sck_q);
  assign load         = period_start && (p_cnt == '0);
  assign accept       = audio_valid_in && !hold_full;

  // Reorder the holding frame so slot 0 MSB sits at the top of the shifter.
  always_comb begin
    hold_ser = '0;
    for (int s = 0; s < SLOTS; s++) begin
      hold_ser[(SLOTS-s)*BIT_WIDTH-1 -: BIT_WIDTH] = hold_dat[s*BIT_WIDTH +: BIT_WIDTH];
    end
  end

`ifdef TDM_TX_UNDERRUN_REPEAT_EN
  logic [FW-1:0] last_ser;

  // Remember the last frame that was genuinely loaded from the holding buffer.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)              last_ser <= '0;
    else if (load && hold_full) last_ser <= hold_ser;
  end

  assign under_ser = last_ser;
`else
  assign under_ser = '0;
`endif

  // Clock divider: sck low for CLK_DIV clocks, then high for CLK_DIV clocks.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (div_wrap) begin
        div_cnt <= '0;
        sck_q   <= ~sck_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Period sequencer and serializer; outputs change only at period starts.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      p_cnt <= '0;
      b_cnt <= '0;
      ser   <= '0;
      ws_q  <= 1'b0;
      sd_q  <= 1'b0;
    end else if (period_start) begin
      if (p_cnt == '0) begin
        ws_q  <= 1'b1;
        sd_q  <= 1'b0;
        b_cnt <= '0;
        p_cnt <= p_cnt + 1'b1;
        ser   <= hold_full ? hold_ser : under_ser;
      end else begin
        ws_q <= 1'b0;
        // Padding periods leave the shifter alone so the next slot starts at its MSB.
        if (b_cnt < B_DATA) begin
          sd_q <= ser[FW-1];
          ser  <= ser << 1;
        end else begin
          sd_q <= 1'b0;
        end
        b_cnt <= (b_cnt == B_LAST) ? '0 : b_cnt + 1'b1;
        p_cnt <= (p_cnt == P_LAST) ? '0 : p_cnt + 1'b1;
      end
    end
  end

  // Holding buffer: a load sees the pre-accept state, so a same-cycle accept survives an underrun.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_dat  <= audio_in;
    end
  end

  // One-cycle status pulses aligned with the ws update.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      fs_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      fs_q <= load;
      ur_q <= load && !hold_full;
    end
  end

  assign audio_ready_out = !hold_full;
  assign sck_out         = sck_q;
  assign ws_out          = ws_q;
  assign sd_out          = sd_q;
  assign frame_start_out = fs_q;
  assign underrun_out    = ur_q;

endmodule
